// File: rtl/bch_col_accumulator_pkg.sv
// Shared field/lane types and FSM encoding for the BCH column accumulator.
// Optional zero-detect outputs are enabled by defining BCH_ACC_ZERO_DETECT_EN.
package bch_pkg;
    localparam int GF_M      = 13;
    localparam int NUM_LANES = 16;

    typedef logic [GF_M-1:0] gf_elem_t;
    typedef gf_elem_t [NUM_LANES-1:0] lane_vec_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;
endpackage

// File: rtl/bch_col_accumulator_if.sv
// Input beat stream and output result handshake of the column accumulator.
// Zero-flag signals exist only when BCH_ACC_ZERO_DETECT_EN is defined.
interface bch_col_accumulator_if #(
    parameter int M     = 13,
    parameter int LANES = 16,
    parameter int CNT_W = 13
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [LANES*M-1:0]   in_p;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*M-1:0]   out_syn;
    logic [CNT_W-1:0]     out_beats;
    logic                 out_overflow;
`ifdef BCH_ACC_ZERO_DETECT_EN
    logic [LANES-1:0]     out_zero;
    logic                 out_all_zero;

    modport slave (
        input  in_valid, in_last, in_p, out_ready,
        output in_ready, out_valid, out_syn, out_beats, out_overflow,
               out_zero, out_all_zero
    );
    modport master (
        output in_valid, in_last, in_p, out_ready,
        input  in_ready, out_valid, out_syn, out_beats, out_overflow,
               out_zero, out_all_zero
    );
`else
    modport slave (
        input  in_valid, in_last, in_p, out_ready,
        output in_ready, out_valid, out_syn, out_beats, out_overflow
    );
    modport master (
        output in_valid, in_last, in_p, out_ready,
        input  in_ready, out_valid, out_syn, out_beats, out_overflow
    );
`endif
endinterface

// File: rtl/bch_col_accumulator_lane.sv
// Single GF(2^M) lane: load or XOR-accumulate, with the combinational
// next value exported so the top can capture a frame's final sum directly.
module bch_acc_lane
    import bch_pkg::*;
#(
    parameter int M = GF_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [M-1:0] din,
    output logic [M-1:0] sum
);
    logic [M-1:0] acc;

    assign sum = load ? din : (acc ^ din);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end
endmodule

// File: rtl/bch_col_accumulator.sv
// 16-lane GF(2^13) frame accumulator with valid/ready result register.
// Define BCH_ACC_ZERO_DETECT_EN to add registered per-lane zero flags.
module bch_col_accumulator
    import bch_pkg::*;
#(
    parameter int M     = GF_M,
    parameter int LANES = NUM_LANES,
    parameter int CNT_W = 13
) (
    input logic                   clk,
    input logic                   rst,
    bch_col_accumulator_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    acc_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                accept;
    logic                beat_mid;
    logic                beat_end;
    logic                from_idle;
    logic [LANES*M-1:0]  result;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // Ready depends only on the output register, never on in_valid.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign beat_mid     = accept && !bus.in_last;
    assign beat_end     = accept && bus.in_last;
    assign from_idle    = (state == ST_IDLE);
    assign cnt_next     = from_idle ? CNT_W'(1) : sat_inc(cnt);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        bch_acc_lane #(.M(M)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (beat_mid),
            .clr  (beat_end),
            .load (from_idle),
            .din  (bus.in_p[k*M +: M]),
            .sum  (result[k*M +: M])
        );
    end

`ifdef BCH_ACC_ZERO_DETECT_EN
    logic [LANES-1:0] zero_vec;

    always_comb begin
        zero_vec = '0;
        for (int k = 0; k < LANES; k++) begin
            zero_vec[k] = (result[k*M +: M] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_zero     <= '0;
            bus.out_all_zero <= 1'b0;
        end else if (beat_end) begin
            bus.out_zero     <= zero_vec;
            bus.out_all_zero <= &zero_vec;
        end
    end
`endif

    // A take clears out_valid; a last beat in the same cycle reloads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            bus.out_valid    <= 1'b0;
            bus.out_syn      <= '0;
            bus.out_beats    <= '0;
            bus.out_overflow <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (beat_mid) begin
                state <= ST_ACCUM;
                cnt   <= cnt_next;
            end else if (beat_end) begin
                state            <= ST_IDLE;
                cnt              <= '0;
                bus.out_valid    <= 1'b1;
                bus.out_syn      <= result;
                bus.out_beats    <= cnt_next;
                bus.out_overflow <= (cnt_next == CNT_MAX);
            end
        end
    end
endmodule

// File: tb/tb_bch_col_accumulator.sv
// Directed self-checking bench for bch_col_accumulator.
// Zero-flag checks are compiled in when BCH_ACC_ZERO_DETECT_EN is defined.
module tb_bch_col_accumulator;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bch_col_accumulator_if #(.M(13), .LANES(16), .CNT_W(13)) bus ();

    bch_col_accumulator #(.M(13), .LANES(16), .CNT_W(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [207:0] obs, input logic [207:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [207:0] p);
        bus.in_valid = v;
        bus.in_last  = l;
        bus.in_p     = p;
    endtask

    initial begin
        // Reset with a last beat presented: it must be dropped.
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 208'h5);
        tick();
        check("rst_in_ready", 208'(bus.in_ready), 208'd1);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, '0);
        tick();
        check("rst_out_valid", 208'(bus.out_valid), 208'd0);
        check("rst_out_syn", bus.out_syn, 208'd0);
        check("rst_out_beats", 208'(bus.out_beats), 208'd0);
        check("rst_out_overflow", 208'(bus.out_overflow), 208'd0);

        // Single-beat frame.
        drive(1'b1, 1'b1, 208'h1ABC);
        tick();
        check("single_valid", 208'(bus.out_valid), 208'd1);
        check("single_syn", bus.out_syn, 208'h1ABC);
        check("single_beats", 208'(bus.out_beats), 208'd1);
        drive(1'b0, 1'b0, '0);
        bus.out_ready = 1'b1;
        tick();
        check("take_clears_valid", 208'(bus.out_valid), 208'd0);

        // Three-beat frame: 1 ^ 2 ^ 4 = 7 in every lane.
        drive(1'b1, 1'b0, {16{13'h0001}});
        tick();
        drive(1'b1, 1'b0, {16{13'h0002}});
        tick();
        check("mid_frame_no_valid", 208'(bus.out_valid), 208'd0);
        drive(1'b1, 1'b1, {16{13'h0004}});
        tick();
        check("three_valid", 208'(bus.out_valid), 208'd1);
        check("three_syn", bus.out_syn, {16{13'h0007}});
        check("three_beats", 208'(bus.out_beats), 208'd3);
        check("three_overflow", 208'(bus.out_overflow), 208'd0);

        // Back-pressure: result held, input stalled.
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, {16{13'h1FFF}});
        #1;
        check("stall_in_ready", 208'(bus.in_ready), 208'd0);
        tick();
        tick();
        check("hold_valid", 208'(bus.out_valid), 208'd1);
        check("hold_syn", bus.out_syn, {16{13'h0007}});
        check("hold_beats", 208'(bus.out_beats), 208'd3);
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", 208'(bus.in_ready), 208'd1);
        tick();
        check("take_reload_valid", 208'(bus.out_valid), 208'd1);
        check("take_reload_syn", bus.out_syn, {16{13'h1FFF}});
        check("take_reload_beats", 208'(bus.out_beats), 208'd1);

        // Back-to-back single-beat frames.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 208'(i));
            tick();
            check("stream_valid", 208'(bus.out_valid), 208'd1);
            check("stream_syn", bus.out_syn, 208'(i));
        end
        drive(1'b0, 1'b0, '0);
        tick();
        check("stream_end_valid", 208'(bus.out_valid), 208'd0);

        // Reset mid-frame discards the partial frame.
        drive(1'b1, 1'b0, {16{13'h0111}});
        tick();
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_no_valid", 208'(bus.out_valid), 208'd0);
        drive(1'b1, 1'b1, 208'h0ABC);
        tick();
        check("abort_next_valid", 208'(bus.out_valid), 208'd1);
        check("abort_next_syn", bus.out_syn, 208'h0ABC);
        check("abort_next_beats", 208'(bus.out_beats), 208'd1);

        // 8193-beat frame: counter saturates, odd count of 1s leaves lane0 = 1.
        drive(1'b1, 1'b0, 208'h1);
        for (int i = 0; i < 8192; i++) tick();
        drive(1'b1, 1'b1, 208'h1);
        tick();
        check("sat_valid", 208'(bus.out_valid), 208'd1);
        check("sat_beats", 208'(bus.out_beats), 208'd8191);
        check("sat_overflow", 208'(bus.out_overflow), 208'd1);
        check("sat_syn", bus.out_syn, 208'h1);
        drive(1'b0, 1'b0, '0);
        tick();

`ifdef BCH_ACC_ZERO_DETECT_EN
        drive(1'b1, 1'b0, {16{13'h0155}});
        tick();
        drive(1'b1, 1'b1, {16{13'h0155}});
        tick();
        check("zero_all_flags", 208'(bus.out_zero), 208'hFFFF);
        check("zero_all_and", 208'(bus.out_all_zero), 208'd1);
        drive(1'b1, 1'b0, {16{13'h0155}});
        tick();
        drive(1'b1, 1'b0, {16{13'h0155}});
        tick();
        drive(1'b1, 1'b1, 208'h1 << (3*13));
        tick();
        check("zero_lane3_flags", 208'(bus.out_zero), 208'hFFF7);
        check("zero_lane3_and", 208'(bus.out_all_zero), 208'd0);
        drive(1'b0, 1'b0, '0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
